// File: rtl/sata_phy_pkg.sv
// Shared constants, TX state encoding and lane helpers
// for the multi-channel SATA PHY interface.
package sata_phy_pkg;

  localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
  localparam logic [7:0]  K28_5    = 8'hBC;
  localparam logic [3:0]  K_BYTE0  = 4'b0001;

  typedef enum logic [1:0] {
    LINKDOWN = 2'd0,
    DATA     = 2'd1,
    AL0      = 2'd2,
    AL1      = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  k;
  } rx_word_t;

  // Dword starting at byte lane L of old, continued in cur.
  function automatic logic [31:0] lane_dw(
    input logic [31:0] cur,
    input logic [31:0] old,
    input logic [1:0]  lane
  );
    logic [63:0] cat;
    cat = {cur, old};
    return cat[{1'b0, lane, 3'b000} +: 32];
  endfunction

  function automatic logic [3:0] lane_k(
    input logic [3:0] cur,
    input logic [3:0] old,
    input logic [1:0] lane
  );
    logic [7:0] cat;
    cat = {cur, old};
    return cat[{1'b0, lane} +: 4];
  endfunction

endpackage

// File: rtl/sata_phy_if_ch.sv
// One SATA channel: TX framing with periodic ALIGN pairs
// and RX comma-lane realignment with slip counting.
module sata_phy_if_ch
  import sata_phy_pkg::*;
#(
  parameter int C_ALIGN_PERIOD  = 256,
  parameter int C_RX_DROP_ALIGN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_up,
  input  logic [31:0] tx_data,
  input  logic        tx_datak,
  output logic        tx_pop,
  output logic [31:0] gtx_txdata,
  output logic [3:0]  gtx_txcharisk,
  input  logic [31:0] gtx_rxdata,
  input  logic [3:0]  gtx_rxcharisk,
  output logic [31:0] rx_data,
  output logic        rx_datak,
  output logic        rx_valid,
  output logic [1:0]  rx_lane,
  output logic [7:0]  rx_slip_cnt
);

  localparam int CW = $clog2(C_ALIGN_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(C_ALIGN_PERIOD - 3);
  localparam logic DROP = (C_RX_DROP_ALIGN != 0);

  tx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] txd_q, txd_d;
  logic [3:0]  txk_q, txk_d;

  rx_word_t    d1_q, d1_d;
  logic        link_d1_q, link_d1_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  slip_q, slip_d;
  logic        blank_q, blank_d;
  logic [31:0] rxd_q, rxd_d;
  logic        rxk_q, rxk_d;
  logic        rxv_q, rxv_d;

  logic        k_onehot;
  logic [1:0]  k_lane;
  logic        comma_hit;
  logic        slip;
  logic [31:0] al_data;
  logic [3:0]  al_k;
  logic        is_align;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txd_d   = ALIGN_DW;
    txk_d   = K_BYTE0;
    tx_pop  = (state_q == DATA);
    unique case (state_q)
      LINKDOWN: begin
        cnt_d = '0;
        if (link_up) state_d = DATA;
      end
      DATA: begin
        txd_d = tx_data;
        txk_d = tx_datak ? K_BYTE0 : 4'b0000;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = AL0;
      end
      AL0: state_d = AL1;
      AL1: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      default: state_d = LINKDOWN;
    endcase
    // Link loss wins over any framing step.
    if (!link_up) state_d = LINKDOWN;
  end

  always_comb begin
    k_onehot = 1'b1;
    k_lane   = 2'd0;
    unique case (1'b1)
      gtx_rxcharisk == 4'b0001: k_lane = 2'd0;
      gtx_rxcharisk == 4'b0010: k_lane = 2'd1;
      gtx_rxcharisk == 4'b0100: k_lane = 2'd2;
      gtx_rxcharisk == 4'b1000: k_lane = 2'd3;
      default: k_onehot = 1'b0;
    endcase
  end

  always_comb begin
    comma_hit = k_onehot &&
      (gtx_rxdata[{k_lane, 3'b000} +: 8] == K28_5);
    slip      = comma_hit && (k_lane != lane_q);
    lane_d    = slip ? k_lane : lane_q;
    slip_d    = slip_q;
    if (slip && (slip_q != 8'hFF)) slip_d = slip_q + 8'd1;
    blank_d   = slip;
    d1_d      = '{data: gtx_rxdata, k: gtx_rxcharisk};
    link_d1_d = link_up;
    al_data   = lane_dw(gtx_rxdata, d1_q.data, lane_q);
    al_k      = lane_k(gtx_rxcharisk, d1_q.k, lane_q);
    is_align  = (al_data == ALIGN_DW) && (al_k == K_BYTE0);
    rxd_d     = al_data;
    rxk_d     = al_k[0];
    // Blank the output formed across a lane change.
    rxv_d     = link_d1_q && !slip && !blank_q &&
                !(DROP && is_align);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LINKDOWN;
      cnt_q     <= '0;
      txd_q     <= ALIGN_DW;
      txk_q     <= K_BYTE0;
      d1_q      <= '0;
      link_d1_q <= 1'b0;
      lane_q    <= 2'd0;
      slip_q    <= 8'd0;
      blank_q   <= 1'b0;
      rxd_q     <= 32'd0;
      rxk_q     <= 1'b0;
      rxv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      txd_q     <= txd_d;
      txk_q     <= txk_d;
      d1_q      <= d1_d;
      link_d1_q <= link_d1_d;
      lane_q    <= lane_d;
      slip_q    <= slip_d;
      blank_q   <= blank_d;
      rxd_q     <= rxd_d;
      rxk_q     <= rxk_d;
      rxv_q     <= rxv_d;
    end
  end

  assign gtx_txdata    = txd_q;
  assign gtx_txcharisk = txk_q;
  assign rx_data       = rxd_q;
  assign rx_datak      = rxk_q;
  assign rx_valid      = rxv_q;
  assign rx_lane       = lane_q;
  assign rx_slip_cnt   = slip_q;

endmodule

// File: rtl/sata_phy_if_mc.sv
// Multi-channel SATA PHY interface: one independent
// channel instance per SATA port on a shared PHY clock.
module sata_phy_if_mc
  import sata_phy_pkg::*;
#(
  parameter int C_NUM_CH        = 2,
  parameter int C_ALIGN_PERIOD  = 256,
  parameter int C_RX_DROP_ALIGN = 1
) (
  input  logic                  phyclk,
  input  logic                  phyreset,
  input  logic [C_NUM_CH-1:0]   ch_reset,
  input  logic [C_NUM_CH-1:0]   link_up,
  input  logic [32*C_NUM_CH-1:0] tx_data,
  input  logic [C_NUM_CH-1:0]   tx_datak,
  output logic [C_NUM_CH-1:0]   tx_pop,
  output logic [32*C_NUM_CH-1:0] gtx_txdata,
  output logic [4*C_NUM_CH-1:0] gtx_txcharisk,
  input  logic [32*C_NUM_CH-1:0] gtx_rxdata,
  input  logic [4*C_NUM_CH-1:0] gtx_rxcharisk,
  output logic [32*C_NUM_CH-1:0] rx_data,
  output logic [C_NUM_CH-1:0]   rx_datak,
  output logic [C_NUM_CH-1:0]   rx_valid,
  output logic [2*C_NUM_CH-1:0] rx_lane,
  output logic [8*C_NUM_CH-1:0] rx_slip_cnt
);

  for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
    logic ch_rst;
    assign ch_rst = phyreset | ch_reset[g];

    sata_phy_if_ch #(
      .C_ALIGN_PERIOD  (C_ALIGN_PERIOD),
      .C_RX_DROP_ALIGN (C_RX_DROP_ALIGN)
    ) u_ch (
      .clk           (phyclk),
      .rst           (ch_rst),
      .link_up       (link_up[g]),
      .tx_data       (tx_data[32*g +: 32]),
      .tx_datak      (tx_datak[g]),
      .tx_pop        (tx_pop[g]),
      .gtx_txdata    (gtx_txdata[32*g +: 32]),
      .gtx_txcharisk (gtx_txcharisk[4*g +: 4]),
      .gtx_rxdata    (gtx_rxdata[32*g +: 32]),
      .gtx_rxcharisk (gtx_rxcharisk[4*g +: 4]),
      .rx_data       (rx_data[32*g +: 32]),
      .rx_datak      (rx_datak[g]),
      .rx_valid      (rx_valid[g]),
      .rx_lane       (rx_lane[2*g +: 2]),
      .rx_slip_cnt   (rx_slip_cnt[8*g +: 8])
    );
  end

endmodule

// File: tb/tb_sata_phy_if_mc.sv
// Directed bench for sata_phy_if_mc: 4 channels, ALIGN
// period 8, RX lane alignment, slips and per-channel reset.
module tb_sata_phy_if_mc;

  localparam int NCH = 4;
  localparam logic [31:0] AL = 32'h7B4A4ABC;

  logic           clk = 1'b0;
  logic           phyreset;
  logic [NCH-1:0] ch_reset;
  logic [NCH-1:0] link_up;
  logic [32*NCH-1:0] tx_data;
  logic [NCH-1:0] tx_datak;
  logic [NCH-1:0] tx_pop;
  logic [32*NCH-1:0] gtx_txdata;
  logic [4*NCH-1:0]  gtx_txcharisk;
  logic [32*NCH-1:0] gtx_rxdata;
  logic [4*NCH-1:0]  gtx_rxcharisk;
  logic [32*NCH-1:0] rx_data;
  logic [NCH-1:0] rx_datak;
  logic [NCH-1:0] rx_valid;
  logic [2*NCH-1:0] rx_lane;
  logic [8*NCH-1:0] rx_slip_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sata_phy_if_mc #(
    .C_NUM_CH        (NCH),
    .C_ALIGN_PERIOD  (8),
    .C_RX_DROP_ALIGN (1)
  ) dut (
    .phyclk        (clk),
    .phyreset      (phyreset),
    .ch_reset      (ch_reset),
    .link_up       (link_up),
    .tx_data       (tx_data),
    .tx_datak      (tx_datak),
    .tx_pop        (tx_pop),
    .gtx_txdata    (gtx_txdata),
    .gtx_txcharisk (gtx_txcharisk),
    .gtx_rxdata    (gtx_rxdata),
    .gtx_rxcharisk (gtx_rxcharisk),
    .rx_data       (rx_data),
    .rx_datak      (rx_datak),
    .rx_valid      (rx_valid),
    .rx_lane       (rx_lane),
    .rx_slip_cnt   (rx_slip_cnt)
  );

  typedef struct {
    logic        lu;
    logic        cr2;
    logic        pop;
    logic [31:0] tx;
    logic        pop2;
    logic [31:0] tx2;
  } tx_vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        v;
    logic [31:0] ed;
    logic        ek;
    logic [1:0]  lane;
    logic [7:0]  slip;
  } rx_vec_t;

  tx_vec_t tv[38];
  rx_vec_t rv[13];
  logic [31:0] nxt[NCH];
  logic [NCH-1:0] popped;

  function automatic tx_vec_t mt(
    input logic lu, input logic cr2,
    input logic pop, input logic [31:0] tx,
    input logic pop2, input logic [31:0] tx2
  );
    tx_vec_t v;
    v.lu = lu; v.cr2 = cr2;
    v.pop = pop; v.tx = tx;
    v.pop2 = pop2; v.tx2 = tx2;
    return v;
  endfunction

  function automatic tx_vec_t ms(
    input logic lu, input logic pop, input logic [31:0] tx
  );
    return mt(lu, 1'b0, pop, tx, pop, tx);
  endfunction

  function automatic rx_vec_t mr(
    input logic [31:0] d, input logic [3:0] k,
    input logic v, input logic [31:0] ed, input logic ek,
    input logic [1:0] lane, input logic [7:0] slip
  );
    rx_vec_t r;
    r.d = d; r.k = k; r.v = v; r.ed = ed; r.ek = ek;
    r.lane = lane; r.slip = slip;
    return r;
  endfunction

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // TX stream: ch2 values listed separately (reset at i27).
    tv[0]  = ms(1, 0, AL);
    tv[1]  = ms(1, 1, AL);
    tv[2]  = ms(1, 1, 1);
    tv[3]  = ms(1, 1, 2);
    tv[4]  = ms(1, 1, 3);
    tv[5]  = ms(1, 1, 4);
    tv[6]  = ms(1, 1, 5);
    tv[7]  = ms(1, 0, 6);
    tv[8]  = ms(1, 0, AL);
    tv[9]  = ms(1, 1, AL);
    tv[10] = ms(1, 1, 7);
    tv[11] = ms(1, 1, 8);
    tv[12] = ms(1, 1, 9);
    tv[13] = ms(1, 1, 10);
    tv[14] = ms(1, 1, 11);
    tv[15] = ms(0, 0, 12);
    tv[16] = ms(0, 0, AL);
    tv[17] = ms(1, 0, AL);
    tv[18] = ms(1, 1, AL);
    tv[19] = ms(1, 1, 13);
    tv[20] = ms(1, 1, 14);
    tv[21] = ms(1, 1, 15);
    tv[22] = ms(1, 1, 16);
    tv[23] = ms(1, 1, 17);
    tv[24] = ms(1, 0, 18);
    tv[25] = ms(1, 0, AL);
    tv[26] = ms(1, 1, AL);
    tv[27] = mt(1, 1, 1, 19, 1, 19);
    tv[28] = mt(1, 0, 1, 20, 0, AL);
    tv[29] = mt(1, 0, 1, 21, 1, AL);
    tv[30] = mt(1, 0, 1, 22, 1, 21);
    tv[31] = mt(1, 0, 1, 23, 1, 22);
    tv[32] = mt(1, 0, 0, 24, 1, 23);
    tv[33] = mt(1, 0, 0, AL, 1, 24);
    tv[34] = mt(1, 0, 1, AL, 1, 25);
    tv[35] = mt(1, 0, 1, 25, 0, 26);
    tv[36] = mt(1, 0, 1, 26, 0, AL);
    tv[37] = mt(1, 0, 1, 27, 1, AL);

    // RX: ALIGN/data at lane 2, then a non-ALIGN comma at lane 1.
    rv[0]  = mr(32'h4ABC0000, 4'b0100, 0, 32'h0, 0, 0, 0);
    rv[1]  = mr(32'h4ABC7B4A, 4'b0100, 0, 32'h0, 0, 2, 1);
    rv[2]  = mr(32'h33447B4A, 4'b0000, 0, AL, 1, 2, 1);
    rv[3]  = mr(32'h77881122, 4'b0000, 0, AL, 1, 2, 1);
    rv[4]  = mr(32'h4ABC5566, 4'b0100, 1, 32'h11223344, 0, 2, 1);
    rv[5]  = mr(32'hBEEF7B4A, 4'b0000, 1, 32'h55667788, 0, 2, 1);
    rv[6]  = mr(32'h0000DEAD, 4'b0000, 0, AL, 1, 2, 1);
    rv[7]  = mr(32'h00000000, 4'b0000, 1, 32'hDEADBEEF, 0, 2, 1);
    rv[8]  = mr(32'h2233BC00, 4'b0010, 1, 32'h0, 0, 2, 1);
    rv[9]  = mr(32'hFEF00D11, 4'b0000, 0, 32'hBC000000, 0, 1, 2);
    rv[10] = mr(32'h020304CA, 4'b0000, 0, 32'h112233BC, 1, 1, 2);
    rv[11] = mr(32'h00000001, 4'b0000, 1, 32'hCAFEF00D, 0, 1, 2);
    rv[12] = mr(32'h00000000, 4'b0000, 1, 32'h01020304, 0, 1, 2);

    phyreset = 1'b1;
    ch_reset = '0;
    link_up = '0;
    tx_data = '0;
    tx_datak = '0;
    gtx_rxdata = '0;
    gtx_rxcharisk = '0;
    repeat (3) step();

    for (int n = 0; n < NCH; n++) begin
      chk("rst_txdata", n, gtx_txdata[32*n +: 32], AL);
      chk("rst_txk", n, 32'(gtx_txcharisk[4*n +: 4]), 32'h1);
      chk("rst_pop", n, 32'(tx_pop[n]), 32'h0);
      chk("rst_rxv", n, 32'(rx_valid[n]), 32'h0);
      chk("rst_rxdata", n, rx_data[32*n +: 32], 32'h0);
      chk("rst_lane", n, 32'(rx_lane[2*n +: 2]), 32'h0);
      chk("rst_slip", n, 32'(rx_slip_cnt[8*n +: 8]), 32'h0);
    end
    phyreset = 1'b0;
    step();

    for (int s = 0; s < 13; s++) begin
      link_up = '1;
      gtx_rxdata = {NCH{rv[s].d}};
      gtx_rxcharisk = {NCH{rv[s].k}};
      for (int n = 0; n < NCH; n++) begin
        chk("rx_valid", s, 32'(rx_valid[n]), 32'(rv[s].v));
        chk("rx_data", s, rx_data[32*n +: 32], rv[s].ed);
        chk("rx_datak", s, 32'(rx_datak[n]), 32'(rv[s].ek));
        chk("rx_lane", s, 32'(rx_lane[2*n +: 2]), 32'(rv[s].lane));
        chk("rx_slip", s, 32'(rx_slip_cnt[8*n +: 8]),
            32'(rv[s].slip));
      end
      step();
    end

    // Alternate comma lane 2/1 every cycle: 300 more slips.
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        gtx_rxdata = {NCH{32'h00BC0000}};
        gtx_rxcharisk = {NCH{4'b0100}};
      end else begin
        gtx_rxdata = {NCH{32'h0000BC00}};
        gtx_rxcharisk = {NCH{4'b0010}};
      end
      step();
      if (i == 99)
        chk("slip_mid", 0, 32'(rx_slip_cnt[7:0]), 32'd102);
    end
    for (int n = 0; n < NCH; n++)
      chk("slip_sat", n, 32'(rx_slip_cnt[8*n +: 8]), 32'd255);

    // Multi-bit K and a non-BC K must leave the lane alone.
    gtx_rxdata = {NCH{32'h00BC0000}};
    gtx_rxcharisk = {NCH{4'b0110}};
    step();
    gtx_rxdata = {NCH{32'h00BD0000}};
    gtx_rxcharisk = {NCH{4'b0100}};
    step();
    gtx_rxdata = '0;
    gtx_rxcharisk = '0;
    step();
    for (int n = 0; n < NCH; n++) begin
      chk("lane_hold", n, 32'(rx_lane[2*n +: 2]), 32'd1);
      chk("slip_hold", n, 32'(rx_slip_cnt[8*n +: 8]), 32'd255);
    end

    link_up = '0;
    repeat (3) step();
    for (int n = 0; n < NCH; n++) nxt[n] = 32'd1;

    for (int i = 0; i < 38; i++) begin
      link_up = {NCH{tv[i].lu}};
      ch_reset = '0;
      ch_reset[2] = tv[i].cr2;
      for (int n = 0; n < NCH; n++) begin
        logic [31:0] ex;
        logic        ep;
        logic [31:0] ed;
        logic [31:0] ek;
        tx_data[32*n +: 32] = {8'(n), nxt[n][23:0]};
        tx_datak[n] = (nxt[n] == 32'd3);
        ex = (n == 2) ? tv[i].tx2 : tv[i].tx;
        ep = (n == 2) ? tv[i].pop2 : tv[i].pop;
        ed = (ex == AL) ? AL : {8'(n), ex[23:0]};
        ek = ((ex == AL) || (ex == 32'd3)) ? 32'h1 : 32'h0;
        chk("tx_pop", i, 32'(tx_pop[n]), 32'(ep));
        chk("gtx_txdata", i, gtx_txdata[32*n +: 32], ed);
        chk("gtx_txk", i, 32'(gtx_txcharisk[4*n +: 4]), ek);
      end
      if (i == 28) begin
        chk("cr2_slip", 2, 32'(rx_slip_cnt[23:16]), 32'd0);
        chk("cr2_lane", 2, 32'(rx_lane[5:4]), 32'd0);
        chk("cr2_rxv", 2, 32'(rx_valid[2]), 32'd0);
        chk("cr2_ch0_slip", 0, 32'(rx_slip_cnt[7:0]), 32'd255);
        chk("cr2_ch3_lane", 3, 32'(rx_lane[7:6]), 32'd1);
      end
      popped = tx_pop;
      step();
      for (int n = 0; n < NCH; n++)
        if (popped[n]) nxt[n] = nxt[n] + 32'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
